// File: rtl/banzai_chip_pkg.sv
// +----------------------------------------------------------------------------+
// | Package : banzai_chip_pkg                                                  |
// | Purpose : Shared opcode and FSM state types for the memristor Bayesian     |
// |           chip command sequencer.                                          |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

package banzai_chip_pkg;

   localparam int OP_W = 3;

   typedef enum logic [OP_W-1:0] {
      OP_NOP       = 3'd0,
      OP_WRITE     = 3'd1,
      OP_LOAD_SEED = 3'd2,
      OP_INFER     = 3'd3,
      OP_READ1     = 3'd4,
      OP_READ8     = 3'd5,
      OP_LOAD_MEM  = 3'd6,
      OP_ILLEGAL   = 3'd7
   } op_e;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SETUP   = 3'd1,
      ST_PULSE   = 3'd2,
      ST_HOLD    = 3'd3,
      ST_RUN     = 3'd4,
      ST_READ    = 3'd5,
      ST_CAPTURE = 3'd6,
      ST_RESP    = 3'd7
   } state_e;

   // Opcodes that follow the SETUP -> PULSE -> HOLD write-style sequence.
   function automatic logic op_has_pulse(input op_e op);
      return (op == OP_WRITE) || (op == OP_LOAD_SEED) || (op == OP_LOAD_MEM);
   endfunction

endpackage

`default_nettype wire

// File: rtl/chip_bitout_sync.sv
// +----------------------------------------------------------------------------+
// | Module  : chip_bitout_sync                                                 |
// | Purpose : Two-flop synchroniser for the chip bit_out bus.                  |
// | Ports   : clk, rst_n (async active-low), d (async input), q (synchronised) |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module chip_bitout_sync #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] r_meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_meta <= '0;
         q      <= '0;
      end else begin
         r_meta <= d;
         q      <= r_meta;
      end
   end

endmodule

`default_nettype wire

// File: rtl/chip_cmd_sequencer.sv
// +----------------------------------------------------------------------------+
// | Module  : chip_cmd_sequencer                                               |
// | Purpose : Expands single host commands into timed pad sequences for the    |
// |           memristor Bayesian chip and returns readout results.             |
// | Ports   : clk, rst_n            clock, async active-low reset              |
// |           cmd_*                 valid/ready command channel                |
// |           rsp_*                 valid/ready response channel (bit_out)     |
// |           err                   one-cycle pulse on illegal opcode          |
// |           chip pads             registered strobes, levels, addresses,     |
// |                                 seeds; bit_out is asynchronous input       |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module chip_cmd_sequencer
   import banzai_chip_pkg::*;
#(
   parameter int ADDR_W    = 8,
   parameter int SEED_W    = 8,
   parameter int OUT_W     = 4,
   parameter int SETUP_CYC = 2,
   parameter int PULSE_CYC = 4,
   parameter int HOLD_CYC  = 1,
   parameter int INFER_CYC = 16,
   parameter int READ_LAT  = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [OP_W-1:0]   cmd_op,
   input  logic [ADDR_W-1:0] cmd_row,
   input  logic [ADDR_W-1:0] cmd_col,
   input  logic [SEED_W-1:0] cmd_data,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [OUT_W-1:0]  rsp_data,
   output logic              err,
   output logic              chip_clk,
   output logic              CBL,
   output logic              CSL,
   output logic              CBLEN,
   output logic              CWL,
   output logic              inference,
   output logic              load_seed,
   output logic              read_1,
   output logic              read_8,
   output logic              load_mem,
   output logic              read_out,
   output logic              stoch_log,
   output logic [ADDR_W-1:0] addr_full_row,
   output logic [ADDR_W-1:0] addr_full_col,
   output logic [SEED_W-1:0] seeds,
   input  logic [OUT_W-1:0]  bit_out
);

   localparam int C_MAX1 = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
   localparam int C_MAX2 = (C_MAX1 > HOLD_CYC) ? C_MAX1 : HOLD_CYC;
   localparam int C_MAX3 = (C_MAX2 > INFER_CYC) ? C_MAX2 : INFER_CYC;
   localparam int C_MAX  = (C_MAX3 > READ_LAT) ? C_MAX3 : READ_LAT;
   localparam int CNT_W  = $clog2(C_MAX + 1);

   // The read strobe spans READ (READ_LAT-1 cycles) plus the single CAPTURE
   // cycle, so capture lands exactly READ_LAT edges after the strobe rises.
   localparam logic [CNT_W-1:0] C_SETUP_LD = CNT_W'(SETUP_CYC - 1);
   localparam logic [CNT_W-1:0] C_PULSE_LD = CNT_W'(PULSE_CYC - 1);
   localparam logic [CNT_W-1:0] C_HOLD_LD  = CNT_W'(HOLD_CYC - 1);
   localparam logic [CNT_W-1:0] C_INFER_LD = CNT_W'(INFER_CYC - 1);
   localparam logic [CNT_W-1:0] C_READ_LD  = CNT_W'(READ_LAT - 2);

   state_e            r_state, w_state_n;
   logic [CNT_W-1:0]  r_cnt, w_cnt_n;
   op_e               r_op, w_op_n, w_cmd_op;
   logic              r_pol, w_pol_n;
   logic              w_accept, w_start, w_busy_n, w_strobe_n, w_write_lv;
   logic [OUT_W-1:0]  w_bit_sync;

   chip_bitout_sync #(.W(OUT_W)) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (bit_out),
      .q     (w_bit_sync)
   );

   // Next-state and phase counter
   always_comb begin
      w_cmd_op  = op_e'(cmd_op);
      w_accept  = cmd_valid && cmd_ready;
      w_start   = w_accept && (w_cmd_op != OP_NOP) && (w_cmd_op != OP_ILLEGAL);
      w_op_n    = w_accept ? w_cmd_op : r_op;
      w_pol_n   = w_accept ? cmd_data[0] : r_pol;
      w_state_n = r_state;
      w_cnt_n   = (r_cnt != '0) ? (r_cnt - CNT_W'(1)) : r_cnt;
      case (r_state)
         ST_IDLE: begin
            if (w_start) begin
               w_state_n = ST_SETUP;
               w_cnt_n   = C_SETUP_LD;
            end
         end
         ST_SETUP: begin
            if (r_cnt == '0) begin
               if (op_has_pulse(r_op)) begin
                  w_state_n = ST_PULSE;
                  w_cnt_n   = C_PULSE_LD;
               end else if (r_op == OP_INFER) begin
                  w_state_n = ST_RUN;
                  w_cnt_n   = C_INFER_LD;
               end else begin
                  w_state_n = ST_READ;
                  w_cnt_n   = C_READ_LD;
               end
            end
         end
         ST_PULSE: begin
            if (r_cnt == '0) begin
               w_state_n = ST_HOLD;
               w_cnt_n   = C_HOLD_LD;
            end
         end
         ST_HOLD: begin
            if (r_cnt == '0) w_state_n = ST_IDLE;
         end
         ST_RUN: begin
            if (r_cnt == '0) begin
               w_state_n = ST_READ;
               w_cnt_n   = C_READ_LD;
            end
         end
         ST_READ: begin
            if (r_cnt == '0) w_state_n = ST_CAPTURE;
         end
         ST_CAPTURE: w_state_n = ST_RESP;
         ST_RESP: begin
            if (rsp_ready) w_state_n = ST_IDLE;
         end
         default: w_state_n = ST_IDLE;
      endcase
   end

   // Pad values are computed for the state about to be entered so the
   // registered pads line up with the registered state.
   always_comb begin
      w_busy_n   = (w_state_n != ST_IDLE);
      w_strobe_n = (w_state_n == ST_READ) || (w_state_n == ST_CAPTURE);
      w_write_lv = w_busy_n && (w_op_n == OP_WRITE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= ST_IDLE;
         r_cnt         <= '0;
         r_op          <= OP_NOP;
         r_pol         <= 1'b0;
         cmd_ready     <= 1'b0;
         rsp_valid     <= 1'b0;
         rsp_data      <= '0;
         err           <= 1'b0;
         chip_clk      <= 1'b0;
         CBL           <= 1'b0;
         CSL           <= 1'b0;
         CBLEN         <= 1'b0;
         CWL           <= 1'b0;
         inference     <= 1'b0;
         load_seed     <= 1'b0;
         read_1        <= 1'b0;
         read_8        <= 1'b0;
         load_mem      <= 1'b0;
         read_out      <= 1'b0;
         stoch_log     <= 1'b0;
         addr_full_row <= '0;
         addr_full_col <= '0;
         seeds         <= '0;
      end else begin
         r_state   <= w_state_n;
         r_cnt     <= w_cnt_n;
         r_op      <= w_op_n;
         r_pol     <= w_pol_n;
         // Dropping ready for the cycle after any accept gives one command per
         // IDLE visit, including NOP and illegal opcodes that stay in IDLE.
         cmd_ready <= (w_state_n == ST_IDLE) && !w_accept;
         rsp_valid <= (w_state_n == ST_RESP);
         err       <= w_accept && (w_cmd_op == OP_ILLEGAL);
         if (r_state == ST_CAPTURE) rsp_data <= w_bit_sync;

         // chip_clk starts high on the first cycle of PULSE/RUN, then toggles.
         if ((w_state_n == ST_PULSE) || (w_state_n == ST_RUN))
            chip_clk <= (r_state != w_state_n) ? 1'b1 : ~chip_clk;
         else
            chip_clk <= 1'b0;

         CBLEN     <= w_write_lv;
         CBL       <= w_write_lv && w_pol_n;
         CSL       <= w_write_lv && !w_pol_n;
         stoch_log <= w_busy_n && (w_op_n == OP_INFER) && w_pol_n;
         CWL       <= (w_state_n == ST_PULSE) && (w_op_n == OP_WRITE);
         load_seed <= (w_state_n == ST_PULSE) && (w_op_n == OP_LOAD_SEED);
         load_mem  <= (w_state_n == ST_PULSE) && (w_op_n == OP_LOAD_MEM);
         inference <= (w_state_n == ST_RUN);
         read_1    <= w_strobe_n && (w_op_n == OP_READ1);
         read_8    <= w_strobe_n && (w_op_n == OP_READ8);
         read_out  <= w_strobe_n && (w_op_n == OP_INFER);

         if (w_start) begin
            addr_full_row <= cmd_row;
            addr_full_col <= cmd_col;
            if (w_cmd_op == OP_LOAD_SEED) seeds <= cmd_data;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_chip_cmd_sequencer.sv
// +----------------------------------------------------------------------------+
// | Module  : tb_chip_cmd_sequencer                                            |
// | Purpose : Self-checking bench for chip_cmd_sequencer: a timeline model     |
// |           compared every cycle plus directed literal expectations.        |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_chip_cmd_sequencer;

   localparam int SETUP_CYC = 2;
   localparam int PULSE_CYC = 4;
   localparam int HOLD_CYC  = 1;
   localparam int INFER_CYC = 16;
   localparam int READ_LAT  = 3;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [2:0] cmd_op = '0;
   logic [7:0] cmd_row = '0, cmd_col = '0, cmd_data = '0;
   logic       rsp_valid;
   logic       rsp_ready = 1'b0;
   logic [3:0] rsp_data;
   logic       err, chip_clk, CBL, CSL, CBLEN, CWL, inference, load_seed;
   logic       read_1, read_8, load_mem, read_out, stoch_log;
   logic [7:0] addr_full_row, addr_full_col, seeds;
   logic [3:0] bit_out = '0;

   always #5 clk = ~clk;

   chip_cmd_sequencer #(
      .ADDR_W(8), .SEED_W(8), .OUT_W(4), .SETUP_CYC(SETUP_CYC), .PULSE_CYC(PULSE_CYC),
      .HOLD_CYC(HOLD_CYC), .INFER_CYC(INFER_CYC), .READ_LAT(READ_LAT)
   ) dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_row(cmd_row), .cmd_col(cmd_col), .cmd_data(cmd_data),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .err(err),
      .chip_clk(chip_clk), .CBL(CBL), .CSL(CSL), .CBLEN(CBLEN), .CWL(CWL),
      .inference(inference), .load_seed(load_seed), .read_1(read_1), .read_8(read_8),
      .load_mem(load_mem), .read_out(read_out), .stoch_log(stoch_log),
      .addr_full_row(addr_full_row), .addr_full_col(addr_full_col), .seeds(seeds),
      .bit_out(bit_out)
   );

   // ---------------- timeline model ----------------
   typedef struct packed {
      logic ready, rsp_valid, err, chip_clk, cbl, csl, cblen, cwl, inference;
      logic load_seed, read_1, read_8, load_mem, read_out, stoch_log;
   } exp_t;

   exp_t       tl[$];
   exp_t       cur = '0;
   exp_t       act;
   bit         in_resp = 0;
   bit         acc;
   logic [7:0] m_row = '0, m_col = '0, m_seed = '0;
   logic [3:0] m_rsp = '0;
   int         n_chk = 0, n_pass = 0;
   bit         chk_en = 0;

   function automatic exp_t idle_rdy();
      exp_t e = '0;
      e.ready = 1'b1;
      return e;
   endfunction

   // Levels held for the whole busy period of a command.
   function automatic exp_t lvl(input int op, input logic d0);
      exp_t e = '0;
      if (op == 1) begin e.cblen = 1'b1; e.cbl = d0; e.csl = ~d0; end
      if (op == 3) e.stoch_log = d0;
      return e;
   endfunction

   function void expand(input int op, input logic d0);
      exp_t lv, e;
      lv = lvl(op, d0);
      for (int i = 0; i < SETUP_CYC; i++) tl.push_back(lv);
      if (op == 1 || op == 2 || op == 6) begin
         for (int i = 0; i < PULSE_CYC; i++) begin
            e = lv;
            e.chip_clk = (i % 2 == 0);
            if (op == 1) e.cwl = 1'b1;
            if (op == 2) e.load_seed = 1'b1;
            if (op == 6) e.load_mem = 1'b1;
            tl.push_back(e);
         end
         for (int i = 0; i < HOLD_CYC; i++) tl.push_back(lv);
      end else begin
         if (op == 3) begin
            for (int i = 0; i < INFER_CYC; i++) begin
               e = lv;
               e.inference = 1'b1;
               e.chip_clk = (i % 2 == 0);
               tl.push_back(e);
            end
         end
         for (int i = 0; i < READ_LAT; i++) begin
            e = lv;
            if (op == 3) e.read_out = 1'b1;
            if (op == 4) e.read_1 = 1'b1;
            if (op == 5) e.read_8 = 1'b1;
            tl.push_back(e);
         end
         e = lv;
         e.rsp_valid = 1'b1;
         tl.push_back(e);
      end
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tl.delete();
         in_resp = 0;
         cur = '0;
         m_row = '0; m_col = '0; m_seed = '0; m_rsp = '0;
      end else begin
         acc = cmd_valid && cur.ready;
         if (in_resp) begin
            if (rsp_ready) begin
               in_resp = 0;
               cur = idle_rdy();
            end
         end else if (tl.size() != 0) begin
            cur = tl.pop_front();
            if (cur.rsp_valid) in_resp = 1;
         end else if (acc) begin
            if (cmd_op == 3'd0 || cmd_op == 3'd7) begin
               cur = '0;
               cur.err = (cmd_op == 3'd7);
            end else begin
               m_row = cmd_row;
               m_col = cmd_col;
               if (cmd_op == 3'd2) m_seed = cmd_data;
               m_rsp = bit_out;
               expand(int'(cmd_op), cmd_data[0]);
               cur = tl.pop_front();
            end
         end else begin
            cur = idle_rdy();
         end
      end
   end

   // ---------------- per-cycle compare and activity counters ----------------
   int c_cwl = 0, c_cblen = 0, c_cbl = 0, c_csl = 0, c_nr = 0, c_rise = 0, c_ls = 0;
   int c_rsp = 0, c_rd1 = 0, c_inf = 0, c_ro = 0, c_sl = 0, c_err = 0, c_acc = 0;
   logic prev_cclk = 1'b0;

   always @(negedge clk) begin
      if (chk_en) begin
         act = {cmd_ready, rsp_valid, err, chip_clk, CBL, CSL, CBLEN, CWL, inference,
                load_seed, read_1, read_8, load_mem, read_out, stoch_log};
         n_chk++;
         if (act !== cur || addr_full_row !== m_row || addr_full_col !== m_col ||
             seeds !== m_seed || (cur.rsp_valid && rsp_data !== m_rsp)) begin
            $display("FAIL model_cycle t=%0t outs=%b exp=%b row=%h/%h col=%h/%h seeds=%h/%h rsp_data=%h/%h",
                     $time, act, cur, addr_full_row, m_row, addr_full_col, m_col,
                     seeds, m_seed, rsp_data, m_rsp);
         end else begin
            n_pass++;
         end
         c_cwl   += int'(CWL);
         c_cblen += int'(CBLEN);
         c_cbl   += int'(CBL);
         c_csl   += int'(CSL);
         c_nr    += int'(!cmd_ready);
         c_rise  += int'(chip_clk && !prev_cclk);
         c_ls    += int'(load_seed);
         c_rsp   += int'(rsp_valid);
         c_rd1   += int'(read_1);
         c_inf   += int'(inference);
         c_ro    += int'(read_out);
         c_sl    += int'(stoch_log);
         c_err   += int'(err);
         c_acc   += int'(cmd_valid && cmd_ready);
      end
      prev_cclk = chip_clk;
   end

   // ---------------- directed stimulus ----------------
   task automatic check(input string nm, input int actual, input int expected);
      n_chk++;
      if (actual !== expected)
         $display("FAIL %s got=%0d expected=%0d t=%0t", nm, actual, expected, $time);
      else
         n_pass++;
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [2:0] op, input logic [7:0] row, input logic [7:0] col,
                       input logic [7:0] data);
      bit ok;
      ok = 0;
      cmd_op = op; cmd_row = row; cmd_col = col; cmd_data = data; cmd_valid = 1'b1;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk);
         if (cmd_ready) ok = 1;
         @(posedge clk);
         #1;
      end
      cmd_valid = 1'b0;
      // Junk on the command bus while busy must have no effect.
      cmd_op = 3'd7; cmd_row = 8'hEE; cmd_col = 8'hDD; cmd_data = 8'hFF;
      if (!ok) check("accept_timeout", 0, 1);
   endtask

   task automatic wait_rsp(input string nm);
      bit seen;
      seen = 0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clk);
         if (rsp_valid) seen = 1;
      end
      if (!seen) check(nm, 0, 1);
   endtask

   int s_cwl, s_cblen, s_cbl, s_csl, s_nr, s_rise, s_ls, s_rsp, s_rd1, s_inf, s_ro, s_sl, s_err, s_acc;

   task automatic snap();
      s_cwl = c_cwl; s_cblen = c_cblen; s_cbl = c_cbl; s_csl = c_csl; s_nr = c_nr;
      s_rise = c_rise; s_ls = c_ls; s_rsp = c_rsp; s_rd1 = c_rd1; s_inf = c_inf;
      s_ro = c_ro; s_sl = c_sl; s_err = c_err; s_acc = c_acc;
   endtask

   initial begin
      cycles(2);
      chk_en = 1;
      check("reset_cmd_ready", int'(cmd_ready), 0);
      check("reset_outputs_zero", int'(|{rsp_valid, rsp_data, err, chip_clk, CBL, CSL, CBLEN,
            CWL, inference, load_seed, read_1, read_8, load_mem, read_out, stoch_log,
            addr_full_row, addr_full_col, seeds}), 0);
      cycles(2);
      rst_n = 1'b1;
      cycles(1);
      check("ready_after_reset", int'(cmd_ready), 1);

      // WRITE, polarity 1
      snap();
      send(3'd1, 8'h12, 8'h34, 8'h01);
      cycles(10);
      check("write_cwl_cycles", c_cwl - s_cwl, 4);
      check("write_cblen_cycles", c_cblen - s_cblen, 7);
      check("write_cbl_cycles", c_cbl - s_cbl, 7);
      check("write_csl_cycles", c_csl - s_csl, 0);
      check("write_busy_cycles", c_nr - s_nr, 7);
      check("write_chip_clk_rises", c_rise - s_rise, 2);
      check("write_row", int'(addr_full_row), 8'h12);
      check("write_col", int'(addr_full_col), 8'h34);

      // LOAD_SEED
      snap();
      send(3'd2, 8'h01, 8'h02, 8'hA5);
      cycles(10);
      check("seed_value", int'(seeds), 8'hA5);
      check("seed_pulse_cycles", c_ls - s_ls, 4);
      check("seed_busy_cycles", c_nr - s_nr, 7);
      check("seed_no_rsp", c_rsp - s_rsp, 0);

      // READ1 with response stall
      bit_out = 4'h9;
      cycles(3);
      snap();
      rsp_ready = 1'b0;
      send(3'd4, 8'h03, 8'h07, 8'h00);
      wait_rsp("read1_rsp_timeout");
      check("read1_rsp_data", int'(rsp_data), 4'h9);
      repeat (10) @(negedge clk);
      check("read1_rsp_data_stable", int'(rsp_data), 4'h9);
      check("read1_rsp_valid_held", int'(rsp_valid), 1);
      check("read1_cmd_ready_stalled", int'(cmd_ready), 0);
      @(posedge clk);
      #1;
      rsp_ready = 1'b1;
      cycles(1);
      rsp_ready = 1'b0;
      cycles(2);
      check("read1_strobe_cycles", c_rd1 - s_rd1, 3);
      check("read1_ready_again", int'(cmd_ready), 1);

      // INFER with stoch_log=1
      bit_out = 4'h6;
      cycles(3);
      snap();
      rsp_ready = 1'b1;
      send(3'd3, 8'h00, 8'h00, 8'h01);
      wait_rsp("infer_rsp_timeout");
      check("infer_rsp_data", int'(rsp_data), 4'h6);
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      cycles(2);
      check("infer_run_cycles", c_inf - s_inf, 16);
      check("infer_chip_clk_rises", c_rise - s_rise, 8);
      check("infer_read_out_cycles", c_ro - s_ro, 3);
      check("infer_stoch_log_cycles", c_sl - s_sl, 22);
      check("infer_one_rsp_cycle", c_rsp - s_rsp, 1);

      // READ8 and LOAD_MEM, model-checked only
      bit_out = 4'hC;
      rsp_ready = 1'b1;
      cycles(3);
      send(3'd5, 8'hAA, 8'h55, 8'h00);
      cycles(12);
      rsp_ready = 1'b0;
      send(3'd6, 8'h0F, 8'hF0, 8'h00);
      cycles(10);

      // Illegal opcode then back-to-back NOPs
      snap();
      send(3'd7, 8'h99, 8'h88, 8'h77);
      cycles(3);
      check("illegal_err_pulses", c_err - s_err, 1);
      check("illegal_no_rsp", c_rsp - s_rsp, 0);
      check("illegal_row_untouched", int'(addr_full_row), 8'h0F);
      snap();
      cmd_op = 3'd0;
      cmd_valid = 1'b1;
      cycles(8);
      cmd_valid = 1'b0;
      cycles(2);
      check("nop_accepts_in_8", c_acc - s_acc, 4);

      // Reset in the middle of a WRITE pulse
      snap();
      send(3'd1, 8'h21, 8'h43, 8'h00);
      cycles(SETUP_CYC + 1);
      check("pre_reset_cwl", int'(CWL), 1);
      rst_n = 1'b0;
      #1;
      check("reset_kills_cwl", int'(CWL), 0);
      check("reset_kills_cblen", int'(CBLEN), 0);
      check("reset_all_pads_zero", int'(|{chip_clk, CBL, CSL, CBLEN, CWL, inference, load_seed,
            read_1, read_8, load_mem, read_out, stoch_log, addr_full_row, addr_full_col, seeds,
            cmd_ready, rsp_valid, err}), 0);
      cycles(2);
      rst_n = 1'b1;
      cycles(1);
      check("ready_after_mid_reset", int'(cmd_ready), 1);
      cycles(8);
      check("mid_reset_no_rsp", c_rsp - s_rsp, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

`default_nettype wire
